cla_gp_input_stage: RTL
=======================

Name: cla_gp_input_stage

Overview:
- Registered front end of the pipelined carry-lookahead adder. It sits directly upstream of the block carry-lookahead unit.
- Accepts operand pairs over a valid/ready handshake and applies add/subtract conditioning: B inverted and carry-in forced to 1 for subtract.
- Produces the per-bit generate/propagate vectors and C0 that the lookahead units consume. P is also reused downstream for the sum XOR.
- Full throughput (one operation per cycle) with a skid buffer so that in_ready is driven from a register.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 (one lookahead group per nibble); other values are a compile-time error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  stage can accept a beat; registered
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- C_in  in  1  carry-in; used only when sub=0
- sub  in  1  1 = A-B (two's complement), 0 = A+B+C_in
- out_valid  out  1  G/P/C0 beat valid
- out_ready  in  1  downstream accepts beat
- G  out  WIDTH  bit generate, A & B_eff
- P  out  WIDTH  bit propagate, A ^ B_eff
- C0  out  1  carry into bit 0
- B_msb  out  1  B_eff[WIDTH-1], for downstream signed overflow

Behaviour:
- Conditioning:
  - B_eff = sub ? ~B : B.
  - C0 = sub ? 1 : C_in.
  - G and P are computed combinationally from the accepted beat and captured in the output register.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_valid must stay high with stable data until accepted.
- Latency: one cycle. A beat accepted at edge N appears on the outputs after edge N when the output register is empty or draining that cycle.
- Storage: two entries, the output register (main) and one skid register.
  - Accept while main empty or draining: data goes to main.
  - Accept while main holding and not draining: data goes to skid, and in_ready falls at the same edge.
  - Main draining while skid full: skid moves to main. in_ready rises the next cycle, with no bubble on the output.
- States, by occupancy:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→ONE on accept with drain.
  - ONE→FULL on accept without drain.
  - ONE→EMPTY on drain without accept.
  - FULL→ONE on drain; no input accept is possible in FULL.
- Simultaneous accept and drain in ONE: the new beat replaces main and the skid stays empty.
- Ordering: beats leave strictly in acceptance order. No beat is dropped or duplicated.
- Output stability: G, P, C0 and B_msb stay stable while out_valid=1 and out_ready=0.
- Reset (async assert, sync-safe release):
  - out_valid=0, in_ready=0, G=0, P=0, C0=0, B_msb=0, skid empty.
  - in_ready goes to 1 on the first clk edge after rst_n deasserts.
  - Reset mid-operation discards all held beats with no partial output.
- Data registers need no reset for function, but are reset to 0 for deterministic waveforms.

Decomposition:
- Shared package cla_pkg:
  - CLA_GROUP = 4 (bits per lookahead group).
  - CLA_DEFAULT_WIDTH = 16.
  - Packed struct gp_beat_t {G, P, C0, B_msb}, parameterised via WIDTH localparams.
- One sub-module, cla_skid_buffer: the generic two-entry valid/ready register pair carrying gp_beat_t.
- The top level holds the conditioning logic and the G/P generation.

Test Plan (WIDTH=16):
- Add: A=0x00FF, B=0x0001, sub=0, C_in=0, out_ready=1 → one cycle later out_valid=1, G=0x0001, P=0x00FE, C0=0, B_msb=0.
- Subtract: A=0x0005, B=0x0003, sub=1 (C_in=0 ignored) → G=0x0004, P=0xFFF9, C0=1, B_msb=1.
- Backpressure: stream 4 beats with out_ready=0 for 3 cycles.
  - in_ready falls after the 2nd accept.
  - Outputs hold beat 1.
  - After out_ready=1, beats 1–4 emerge in order on consecutive cycles.
- Full throughput: in_valid and out_ready held high for 8 beats → 8 outputs on 8 consecutive cycles, in_ready constantly 1.
- Reset mid-stream: FULL state, pull rst_n low between edges.
  - out_valid and in_ready go to 0 immediately, without waiting for a clock edge.
  - After release, in_ready=1 at the next edge and no stale beat appears.
- Carry-in edge: A=0xFFFF, B=0x0000, C_in=1, sub=0 → G=0x0000, P=0xFFFF, C0=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// The lookahead group size, the default operand width and the G/P beat layout live here.
package cla_pkg;

  localparam int unsigned CLA_GROUP         = 4;
  localparam int unsigned CLA_DEFAULT_WIDTH = 16;
  localparam int unsigned CLA_BEAT_WIDTH    = CLA_DEFAULT_WIDTH;

  typedef struct packed {
    logic [CLA_BEAT_WIDTH-1:0] g;
    logic [CLA_BEAT_WIDTH-1:0] p;
    logic                      c0;
    logic                      b_msb;
  } gp_beat_t;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } skid_state_e;

  // Packed size of a G/P beat for a given operand width.
  function automatic int unsigned gp_beat_bits(input int unsigned width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/cla_gp_input_stage_if.sv
// Operand-in / G-P-out handshake bundle of the carry-lookahead input stage.
// The slave modport is the stage itself; the master modport is its environment.
interface cla_gp_input_stage_if
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] G;
  logic [WIDTH-1:0] P;
  logic             C0;
  logic             B_msb;

  modport master (
    output in_valid,
    input  in_ready,
    output A,
    output B,
    output C_in,
    output sub,
    input  out_valid,
    output out_ready,
    input  G,
    input  P,
    input  C0,
    input  B_msb
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  A,
    input  B,
    input  C_in,
    input  sub,
    output out_valid,
    input  out_ready,
    output G,
    output P,
    output C0,
    output B_msb
  );

endinterface

// File: rtl/cla_skid_buffer.sv
// Two-entry valid/ready register pair (main output register plus one skid entry).
// Full throughput with in_ready taken straight from a flop.
module cla_skid_buffer
  import cla_pkg::*;
#(
  parameter type beat_t = gp_beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_data
);

  skid_state_e state_q, state_d;
  beat_t       main_q, main_d;
  beat_t       skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic        accept, drain;

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign drain     = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/cla_gp_input_stage.sv
// Registered front end of the pipelined CLA: add/subtract conditioning of B and the carry-in,
// per-bit generate/propagate, and a skid-buffered output register.
module cla_gp_input_stage
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  cla_gp_input_stage_if.slave bus
);

  if ((WIDTH == 0) || ((WIDTH % CLA_GROUP) != 0)) begin : g_width_check
    $error("cla_gp_input_stage: WIDTH must be a non-zero multiple of the lookahead group size");
  end

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             c0;
    logic             b_msb;
  } stage_beat_t;

  logic [WIDTH-1:0] b_eff;
  stage_beat_t      in_beat;
  stage_beat_t      out_beat;

  // Subtract is A + ~B + 1, so the carry-in is forced high and C_in ignored.
  always_comb begin
    b_eff         = bus.sub ? ~bus.B : bus.B;
    in_beat.g     = bus.A & b_eff;
    in_beat.p     = bus.A ^ b_eff;
    in_beat.c0    = bus.sub | bus.C_in;
    in_beat.b_msb = b_eff[WIDTH-1];
  end

  cla_skid_buffer #(
    .beat_t (stage_beat_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_beat),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_beat)
  );

  assign bus.G     = out_beat.g;
  assign bus.P     = out_beat.p;
  assign bus.C0    = out_beat.c0;
  assign bus.B_msb = out_beat.b_msb;

endmodule
